// File: rtl/rsdec_pkg.sv
// Shared GF(2^8) arithmetic (poly 0x11D, alpha = 0x02) and FSM state type
// for the Reed-Solomon Chien/Forney evaluator.
package rsdec_pkg;

  localparam logic [8:0] GF_POLY = 9'h11D;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_PRESCALE,
    ST_SEARCH,
    ST_DRAIN
  } state_t;

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int unsigned i = 0; i < 8; i++) begin
      if (b[i]) p ^= x;
      x = x[7] ? ((x << 1) ^ GF_POLY[7:0]) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] gf_pow(input int unsigned k);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned i = 0; i < (k % 255); i++) r = gf_mul(r, 8'h02);
    return r;
  endfunction

  // a^254 is the multiplicative inverse for a != 0 and yields 0 for a == 0
  function automatic logic [7:0] gf_inv(input logic [7:0] a);
    logic [7:0] r;
    r = 8'h01;
    for (int unsigned i = 0; i < 254; i++) r = gf_mul(r, a);
    return r;
  endfunction

endpackage

// File: rtl/rsdec_gf_mul.sv
// Combinational 8x8 GF(2^8) multiplier.
module rsdec_gf_mul
  import rsdec_pkg::*;
(
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] p
);

  always_comb begin
    p = gf_mul(a, b);
  end

endmodule

// File: rtl/rsdec_chien_forney_p.sv
// Chien search plus Forney error evaluator: serial coefficient load, optional
// shortening prescale, one codeword position per un-held cycle.
module rsdec_chien_forney_p
  import rsdec_pkg::*;
#(
  parameter int unsigned L_TERMS = 16,
  parameter int unsigned O_TERMS = 16,
  parameter int unsigned N       = 255,
  parameter int unsigned FCR     = 0
) (
  input  logic                             clk,
  input  logic                             clrn,
  input  logic                             load,
  input  logic [7:0]                       lambda,
  input  logic [7:0]                       omega,
  input  logic [$clog2(L_TERMS+1)-1:0]     deg,
  input  logic                             start,
  input  logic                             hold,
  output logic                             ready,
  output logic                             out_valid,
  output logic [7:0]                       out_error,
  output logic                             out_root,
  output logic                             out_last,
  output logic                             done,
  output logic [7:0]                       err_count,
  output logic                             fail
);

  localparam int unsigned DW        = $clog2(L_TERMS + 1);
  localparam int unsigned S         = 255 - N;
  localparam logic [7:0]  XF_INIT   = gf_pow((FCR * S) % 255);
  localparam logic [7:0]  ALPHA_FCR = gf_pow(FCR % 255);
  localparam logic [7:0]  K_LAST    = 8'(N - 1);

  state_t state, state_next;

  logic [7:0] l      [L_TERMS];
  logic [7:0] l_step [L_TERMS];
  logic [7:0] l_pre  [L_TERMS];
  logic [7:0] o      [O_TERMS];
  logic [7:0] o_step [O_TERMS];
  logic [7:0] o_pre  [O_TERMS];
  logic [7:0] xf;
  logic [7:0] k;
  logic [DW-1:0] deg_r;

  logic [7:0] even, odd, num;

  logic       s1_valid, s1_root, s1_last;
  logic [7:0] s1_odd, s1_num, s1_xf;

  logic [7:0] inv_rom [256];
  logic [7:0] quot, err_val;

  for (genvar j = 0; j < L_TERMS; j++) begin : g_l_const
    localparam logic [7:0] AJ  = gf_pow(j);
    localparam logic [7:0] AJS = gf_pow((j * S) % 255);
    assign l_step[j] = gf_mul(l[j], AJ);
    assign l_pre[j]  = gf_mul(l[j], AJS);
  end

  for (genvar j = 0; j < O_TERMS; j++) begin : g_o_const
    localparam logic [7:0] AJ  = gf_pow(j);
    localparam logic [7:0] AJS = gf_pow((j * S) % 255);
    assign o_step[j] = gf_mul(o[j], AJ);
    assign o_pre[j]  = gf_mul(o[j], AJS);
  end

  for (genvar a = 0; a < 256; a++) begin : g_inv_rom
    assign inv_rom[a] = gf_inv(8'(a));
  end

  assign ready = (state == ST_IDLE);

  // FSM: DRAIN exits on done regardless of hold so the pulse cannot repeat
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state <= ST_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (state == ST_DRAIN) begin
      if (done) state_next = ST_IDLE;
    end else if (!hold) begin
      unique case (state)
        ST_IDLE:     if (start && !load) state_next = ST_PRESCALE;
        ST_PRESCALE: state_next = ST_SEARCH;
        ST_SEARCH:   if (k == K_LAST) state_next = ST_DRAIN;
        default:     state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int unsigned i = 0; i < L_TERMS; i++) l[i] <= '0;
      for (int unsigned i = 0; i < O_TERMS; i++) o[i] <= '0;
      xf <= '0;
      k  <= '0;
    end else if (!hold) begin
      unique case (state)
        ST_IDLE: begin
          if (load) begin
            l[0] <= lambda;
            o[0] <= omega;
            for (int unsigned i = 1; i < L_TERMS; i++) l[i] <= l[i-1];
            for (int unsigned i = 1; i < O_TERMS; i++) o[i] <= o[i-1];
          end
        end
        ST_PRESCALE: begin
          for (int unsigned i = 0; i < L_TERMS; i++) l[i] <= l_pre[i];
          for (int unsigned i = 0; i < O_TERMS; i++) o[i] <= o_pre[i];
          xf <= XF_INIT;
          k  <= '0;
        end
        ST_SEARCH: begin
          for (int unsigned i = 0; i < L_TERMS; i++) l[i] <= l_step[i];
          for (int unsigned i = 0; i < O_TERMS; i++) o[i] <= o_step[i];
          xf <= gf_mul(xf, ALPHA_FCR);
          k  <= k + 8'd1;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    even = '0;
    odd  = '0;
    num  = '0;
    for (int unsigned i = 0; i < L_TERMS; i++) begin
      if ((i % 2) == 0) even ^= l[i];
      else              odd  ^= l[i];
    end
    for (int unsigned i = 0; i < O_TERMS; i++) num ^= o[i];
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      s1_valid <= 1'b0;
      s1_root  <= 1'b0;
      s1_last  <= 1'b0;
      s1_odd   <= '0;
      s1_num   <= '0;
      s1_xf    <= '0;
    end else if (!hold) begin
      s1_valid <= (state == ST_SEARCH);
      if (state == ST_SEARCH) begin
        s1_root <= (even == odd);
        s1_last <= (k == K_LAST);
        s1_odd  <= odd;
        s1_num  <= num;
        s1_xf   <= xf;
      end
    end
  end

  rsdec_gf_mul u_mul_num (
    .a (s1_num),
    .b (inv_rom[s1_odd]),
    .p (quot)
  );

  rsdec_gf_mul u_mul_xf (
    .a (quot),
    .b (s1_xf),
    .p (err_val)
  );

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      out_valid <= 1'b0;
      out_error <= '0;
      out_root  <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      out_valid <= !hold && s1_valid;
      if (!hold && s1_valid) begin
        out_root  <= s1_root;
        out_last  <= s1_last;
        out_error <= (s1_root && (s1_odd != 8'h00)) ? err_val : 8'h00;
      end
    end
  end

  // count is bumped as stage 2 loads, so it already includes the last root at done
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      done      <= 1'b0;
      err_count <= '0;
      fail      <= 1'b0;
      deg_r     <= '0;
    end else begin
      done <= 1'b0;
      if (!hold) begin
        if (state == ST_IDLE && start && !load) begin
          err_count <= '0;
          fail      <= 1'b0;
          deg_r     <= deg;
        end else if (state == ST_DRAIN && out_last && !done) begin
          done <= 1'b1;
          fail <= fail | (err_count != 8'(deg_r));
        end else if (s1_valid && s1_root) begin
          if (err_count != 8'hFF) err_count <= err_count + 8'd1;
          if (s1_odd == 8'h00) fail <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rsdec_chien_forney_p.sv
// Directed bench: three parameterisations (default, FCR=1, N=204) driven in
// lockstep; one instance is checked per vector against hand-derived results.
module tb_rsdec_chien_forney_p;

  logic       clk = 1'b0;
  logic       clrn;
  logic       load, start, hold;
  logic [4:0] deg;
  logic [7:0] lambda [3];
  logic [7:0] omega  [3];

  logic [2:0] ready, out_valid, out_root, out_last, done, fail;
  logic [7:0] out_error [3];
  logic [7:0] err_count [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  rsdec_chien_forney_p #(.L_TERMS(16), .O_TERMS(16), .N(255), .FCR(0)) u_def (
    .clk(clk), .clrn(clrn), .load(load), .lambda(lambda[0]), .omega(omega[0]),
    .deg(deg), .start(start), .hold(hold), .ready(ready[0]), .out_valid(out_valid[0]),
    .out_error(out_error[0]), .out_root(out_root[0]), .out_last(out_last[0]),
    .done(done[0]), .err_count(err_count[0]), .fail(fail[0]));

  rsdec_chien_forney_p #(.L_TERMS(16), .O_TERMS(16), .N(255), .FCR(1)) u_fcr (
    .clk(clk), .clrn(clrn), .load(load), .lambda(lambda[1]), .omega(omega[1]),
    .deg(deg), .start(start), .hold(hold), .ready(ready[1]), .out_valid(out_valid[1]),
    .out_error(out_error[1]), .out_root(out_root[1]), .out_last(out_last[1]),
    .done(done[1]), .err_count(err_count[1]), .fail(fail[1]));

  rsdec_chien_forney_p #(.L_TERMS(16), .O_TERMS(16), .N(204), .FCR(0)) u_short (
    .clk(clk), .clrn(clrn), .load(load), .lambda(lambda[2]), .omega(omega[2]),
    .deg(deg), .start(start), .hold(hold), .ready(ready[2]), .out_valid(out_valid[2]),
    .out_error(out_error[2]), .out_root(out_root[2]), .out_last(out_last[2]),
    .done(done[2]), .err_count(err_count[2]), .fail(fail[2]));

  typedef struct {
    string      name;
    int         inst;
    logic [7:0] l2, l1, l0, o0;
    logic [4:0] deg;
    int         hold_at;
    int         poke_at;
    int         exp_n;
    int         exp_root_k;
    logic [7:0] exp_err;
    int         exp_last;
    int         exp_cnt;
    int         exp_fail;
  } vec_t;

  vec_t tbl [5];

  function automatic logic [7:0] tb_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1D) : (x << 1);
    end
    return p;
  endfunction

  function automatic logic [7:0] tb_pow(input int e);
    logic [7:0] r;
    r = 8'h01;
    for (int i = 0; i < e; i++) r = tb_mul(r, 8'h02);
    return r;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic load_coeffs(input vec_t v);
    for (int i = 15; i >= 0; i--) begin
      @(negedge clk);
      load = 1'b1;
      for (int u = 0; u < 3; u++) begin
        lambda[u] = (i == 2) ? v.l2 : (i == 1) ? v.l1 : (i == 0) ? v.l0 : 8'h00;
        omega[u]  = (i == 0) ? v.o0 : 8'h00;
      end
    end
    @(negedge clk);
    load = 1'b0;
  endtask

  task automatic wait_idle();
    for (int c = 0; c < 600 && ready != 3'b111; c++) @(negedge clk);
    chk("idle_wait", int'(ready), 7);
  endtask

  task automatic run_case(input vec_t v, input bit do_load);
    int cyc, npos, nroots, nlast, bad_err, first_cyc, last_cyc, last_pos, done_cyc, root_k;
    int cnt, fl, id;
    logic [7:0] root_err;
    bit seen_done, fin;
    id = v.inst;
    npos = 0; nroots = 0; nlast = 0; bad_err = 0; first_cyc = -1; last_cyc = -1;
    last_pos = -1; done_cyc = -1; root_k = -1; root_err = 8'h00; cnt = -1; fl = -1;
    seen_done = 1'b0; fin = 1'b0;
    if (do_load) load_coeffs(v);
    @(negedge clk);
    deg = v.deg;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    cyc = 0;
    while (!fin && cyc < 700) begin
      @(posedge clk);
      cyc++;
      #1;
      if (seen_done) begin
        chk({v.name, "_ready_after_done"}, int'(ready[id]), 1);
        fin = 1'b1;
      end else begin
        if (out_valid[id]) begin
          if (first_cyc < 0) first_cyc = cyc;
          if (out_root[id]) begin
            nroots++;
            root_k = npos;
            root_err = out_error[id];
          end else if (out_error[id] != 8'h00) begin
            bad_err++;
          end
          if (out_last[id]) begin
            nlast++;
            last_cyc = cyc;
            last_pos = npos;
          end
          npos++;
        end else if (v.hold_at >= 0 && cyc > v.hold_at && cyc <= v.hold_at + 5) begin
          chk({v.name, "_valid_in_hold"}, int'(out_valid[id]), 0);
        end
        if (done[id]) begin
          seen_done = 1'b1;
          done_cyc = cyc;
          cnt = int'(err_count[id]);
          fl = int'(fail[id]);
          chk({v.name, "_ready_at_done"}, int'(ready[id]), 0);
        end
      end
      hold = (v.hold_at >= 0 && cyc >= v.hold_at && cyc < v.hold_at + 5);
      if (v.poke_at >= 0 && cyc == v.poke_at) begin
        load = 1'b1;
        start = 1'b1;
        for (int u = 0; u < 3; u++) begin
          lambda[u] = 8'hFF;
          omega[u]  = 8'hFF;
        end
      end else begin
        load = 1'b0;
        start = 1'b0;
      end
    end
    hold = 1'b0; load = 1'b0; start = 1'b0;
    if (!fin) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: no done within 700 cycles", v.name);
    end
    chk({v.name, "_first_lat"}, first_cyc, 3);
    chk({v.name, "_n_out"}, npos, v.exp_n);
    chk({v.name, "_n_roots"}, nroots, 1);
    chk({v.name, "_root_k"}, root_k, v.exp_root_k);
    chk({v.name, "_root_err"}, int'(root_err), int'(v.exp_err));
    chk({v.name, "_nonroot_err"}, bad_err, 0);
    chk({v.name, "_n_last"}, nlast, 1);
    chk({v.name, "_last_pos"}, last_pos, v.exp_n - 1);
    chk({v.name, "_last_lat"}, last_cyc, v.exp_last);
    chk({v.name, "_done_lat"}, done_cyc, v.exp_last + 1);
    chk({v.name, "_err_count"}, cnt, v.exp_cnt);
    chk({v.name, "_fail"}, fl, v.exp_fail);
    wait_idle();
  endtask

  initial begin
    vec_t vs;
    clrn = 1'b0; load = 1'b0; start = 1'b0; hold = 1'b0; deg = '0;
    for (int u = 0; u < 3; u++) begin
      lambda[u] = 8'h00;
      omega[u]  = 8'h00;
    end

    //            name         inst l2     l1            l0     o0     deg hold poke n    root err    last cnt fail
    tbl[0] = '{"single",    0, 8'h00, 8'h02,       8'h01, 8'h5A, 5'd1, -1, -1, 255, 254, 8'h5A, 257, 1, 0};
    tbl[1] = '{"fcr1",      1, 8'h00, 8'h02,       8'h01, 8'hB4, 5'd1, -1, -1, 255, 254, 8'h5A, 257, 1, 0};
    tbl[2] = '{"short",     2, 8'h00, tb_pow(194), 8'h01, 8'h33, 5'd1, -1, -1, 204, 10,  8'h33, 206, 1, 0};
    tbl[3] = '{"degen",     0, 8'h01, 8'h00,       8'h01, 8'h5A, 5'd2, -1, -1, 255, 0,   8'h00, 257, 1, 1};
    tbl[4] = '{"hold_busy", 0, 8'h00, 8'h02,       8'h01, 8'h5A, 5'd1, 100, 150, 255, 254, 8'h5A, 262, 1, 0};

    repeat (3) @(negedge clk);
    chk("rst_ready", int'(ready), 7);
    chk("rst_valid", int'(out_valid), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_fail", int'(fail), 0);
    chk("rst_err_count", int'(err_count[0]), 0);
    clrn = 1'b1;
    @(negedge clk);

    for (int t = 0; t < 5; t++) run_case(tbl[t], 1'b1);

    // asynchronous reset in the middle of a search
    load_coeffs(tbl[0]);
    @(negedge clk);
    deg = 5'd1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (50) @(negedge clk);
    chk("pre_rst_busy", int'(ready[0]), 0);
    chk("pre_rst_valid", int'(out_valid[0]), 1);
    clrn = 1'b0;
    #1;
    chk("mid_rst_ready", int'(ready[0]), 1);
    chk("mid_rst_valid", int'(out_valid[0]), 0);
    chk("mid_rst_error", int'(out_error[0]), 0);
    chk("mid_rst_root", int'(out_root[0]), 0);
    chk("mid_rst_last", int'(out_last[0]), 0);
    chk("mid_rst_done", int'(done[0]), 0);
    chk("mid_rst_count", int'(err_count[0]), 0);
    chk("mid_rst_fail", int'(fail[0]), 0);
    @(negedge clk);
    clrn = 1'b1;
    @(negedge clk);
    run_case(tbl[0], 1'b1);

    // load+start together: shift only. Registers become l2=02 l1=01 l0=00,
    // o1=5A o0=01, giving a root at k=254 with error 0x5A ^ 0x02 = 0x58.
    @(negedge clk);
    load = 1'b1;
    start = 1'b1;
    deg = 5'd1;
    for (int u = 0; u < 3; u++) begin
      lambda[u] = 8'h00;
      omega[u]  = 8'h01;
    end
    @(negedge clk);
    load = 1'b0;
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      chk("ls_ready", int'(ready[0]), 1);
      chk("ls_valid", int'(out_valid[0]), 0);
      @(negedge clk);
    end
    vs = '{"shifted", 0, 8'h00, 8'h00, 8'h00, 8'h00, 5'd1, -1, -1, 255, 254, 8'h58, 257, 1, 0};
    run_case(vs, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rsdec_chien_forney_p.md
# rsdec_chien_forney_p

Parametrised Chien search plus Forney error-value evaluator for the GF(2^8) Reed-Solomon decoder (field polynomial 0x11D, α = 0x02).
- Position in the decoder: sits after the key-equation solver and before the correction FIFO.
- Accepts Λ(x) and Ω(x) coefficients serially and runs an autonomous N-cycle search.
- Emits one error value per codeword position, with a registered root-count check.
- Generalises the fixed 16-term, unshortened evaluator:
  - Generic term count.
  - Shortened codes via one-cycle prescale.
  - Arbitrary first consecutive root (FCR).
  - Internal odd-term inversion.
  - Flow-control hold.
  - Decode-failure flag.

## Interface
- L_TERMS, 16: number of Λ coefficient registers (2..32).
- O_TERMS, 16: number of Ω coefficient registers (1..32).
- N, 255: codeword length; shortening S = 255-N (N in 2..255).
- FCR, 0: first consecutive root exponent (0..254).
- clk  in  1  clock, rising edge.
- clrn  in  1  reset, asynchronous, active-low.
- load  in  1  shift one Λ and one Ω coefficient in (IDLE only).
- lambda  in  8  Λ coefficient, highest index first.
- omega  in  8  Ω coefficient, highest index first.
- deg  in  $clog2(L_TERMS+1)  degree of Λ, sampled with start.
- start  in  1  begin search (IDLE only).
- hold  in  1  freeze search and pipeline.
- ready  out  1  high in IDLE.
- out_valid  out  1  out_error/out_root valid for one position.
- out_error  out  8  error value for this position (0 if no root).
- out_root  out  1  Λ(α^(S+k)) = 0.
- out_last  out  1  with out_valid at k = N-1.
- done  out  1  one-cycle pulse; err_count/fail valid.
- err_count  out  8  roots found this search.
- fail  out  1  err_count ≠ deg, or root with odd(x) = 0.

## Operation
- **FSM IDLE → PRESCALE → SEARCH → DRAIN → IDLE.**
- **IDLE, load = 1:**
  - l[0] ← lambda and l[j] ← l[j-1].
  - o[0] ← omega and o[j] ← o[j-1].
  - After L_TERMS loads, l[j] holds λ_j (same for Ω with O_TERMS; the shorter chain simply ignores extra loads' overflow).
- **IDLE, start = 1 and load = 0:**
  - Capture deg.
  - Clear err_count and fail.
  - Go to PRESCALE.
  - load has priority when both are high; start is then ignored.
- **PRESCALE (1 cycle):**
  - l[j] ← l[j]·α^(jS) and o[j] ← o[j]·α^(jS).
  - xf ← α^(FCR·S).
  - k ← 0.
- **SEARCH (N un-held cycles):**
  - Stage 0 forms, from current registers:
    - even = XOR of l[even j].
    - odd = XOR of l[odd j].
    - num = XOR of o[j].
  - Registers are then updated: l[j] ← l[j]·α^j, o[j] ← o[j]·α^j, xf ← xf·α^FCR, k ← k+1.
  - After k = N-1 go to DRAIN.
- **Pipeline:**
  - Stage 1 registers even, odd, num, xf, and the flags root = (even == odd) and last.
  - Stage 2 produces out_error = root ? num·inv(odd)·xf : 0, and out_root = root.
  - When root and odd = 0: out_error = 0 and fail ← 1.
- **Root counting:**
  - err_count increments on each out_valid with out_root.
  - It saturates at 255.
- **DRAIN:**
  - Wait for the final out_valid.
  - Then raise done for one cycle and set fail |= (err_count ≠ deg), using the post-increment count.
  - Return to IDLE.
- **Busy behaviour:** load and start are ignored outside IDLE.
- **hold:**
  - Freezes FSM, k, all l/o/xf registers and both pipeline stages.
  - out_valid is low during hold cycles; out_error/out_root/out_last keep their values; no position is lost or repeated.
- **Reset (any time):**
  - All coefficient and pipeline registers are 0.
  - The FSM returns to IDLE.
  - ready = 1; out_valid, out_error, out_root, out_last, done, err_count and fail are 0.

## Timing
- start sampled at edge E0, then PRESCALE at E1.
- First out_valid appears after E3 (3 cycles after start), assuming no hold.
- out_valid is contiguous for N cycles without hold; out_last accompanies the N-th.
- done is asserted the cycle after out_last; ready returns the cycle after done.
- Throughput: one position per un-held cycle.
- Load latency: L_TERMS cycles; ready stays high during loading.

## Structure
- Package rsdec_pkg holds:
  - GF_POLY = 9'h11D.
  - gf_mul (function).
  - gf_pow(k).
  - gf_inv(a), used as a constant ROM.
  - The state enum.
- All α^j, α^(jS) and α^FCR constant multipliers are elaborated from gf_pow at parameter time.
- Sub-module rsdec_gf_mul (combinational 8×8 GF multiplier) is instantiated twice in stage 2.

## Test plan
- **Reset:** assert clrn = 0 mid-SEARCH → next cycle ready = 1, all outputs 0. Release, reload, start → normal run.
- **Single error, defaults:**
  - Load Λ = 14×0x00, 0x02, 0x01 and Ω = 15×0x00, 0x5A; deg = 1; start.
  - Expect 255 out_valid, with only k = 254 having out_root = 1 and out_error = 0x5A, and out_last there.
  - Then done, err_count = 1, fail = 0.
- **FCR = 1:**
  - Same Λ, Ω0 = 0xB4 (0x5A·α).
  - Expect root at k = 254, out_error = 0x5A.
- **Shortened N = 204, S = 51:**
  - λ1 = gf_pow(194), λ0 = 1, Ω0 = 0x33.
  - Expect 204 outputs, root only at k = 10 with out_error = 0x33, fail = 0.
- **Degenerate root:**
  - Λ = 1 + x² (λ2 = 0x01, λ0 = 0x01), deg = 2.
  - Expect root at k = 0 with out_error = 0; err_count = 1, fail = 1.
- **Hold and protocol:**
  - Hold for 5 cycles mid-search: output stream identical to the single-error case, out_last delayed by 5 cycles.
  - start or load while busy: no effect.
  - load and start together in IDLE: coefficient shift only, no search.
